// File: rtl/alu_result_fifo.sv
// Capture stage for the 4-bit sequential ALU: detects rising edges of the done flag,
// queues {sign, zero, carry, result} in a show-ahead FIFO and tracks op count / overflow.

module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    alu_in,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [6:0]    rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    op_count
);

  localparam int AW = $clog2(DEPTH);

  logic          done_q,     done_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          ovf_q,      ovf_d;
  logic [7:0]    op_count_q, op_count_d;
  logic [6:0]    mem_q [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          wr_ok_s;
  logic          drop_s;
  logic [6:0]    wr_data_s;

  // Event decode and next-state for pointers, count and flags
  always_comb begin
    done_d     = alu_in[4];
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    op_count_d = op_count_q;

    push_s    = alu_in[4] & ~done_q;
    full_s    = (count_q == CW'(DEPTH));
    empty_s   = (count_q == {CW{1'b0}});
    pop_s     = rd_en & ~empty_s;
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    wr_ok_s   = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    wr_data_s = {alu_in[7:5], alu_in[3:0]};

    if (push_s) begin
      op_count_d = op_count_q + 8'd1;
    end else begin
      op_count_d = op_count_q;
    end

    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q     <= 1'b0;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      ovf_q      <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      done_q     <= done_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      op_count_q <= op_count_d;
    end
  end

  // Storage array; contents need no reset because rd_data is gated by rd_valid
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_s;
    end
  end

  // Show-ahead head entry and status outputs
  always_comb begin
    rd_valid = ~empty_s;
    if (!empty_s) begin
      rd_data = mem_q[rd_ptr_q];
    end else begin
      rd_data = 7'd0;
    end
    count    = count_q;
    full     = full_s;
    overflow = ovf_q;
    op_count = op_count_q;
  end

  alu_result_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk      (clk),
    .reset    (reset),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full)
  );

endmodule

// Structural invariants of the FIFO status outputs.
module alu_result_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    rd_data,
  input  logic          rd_valid,
  input  logic [CW-1:0] count,
  input  logic          full
);

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH));
  a_full_match: assert property (@(posedge clk) disable iff (!reset)
    full == (count == CW'(DEPTH)));
  a_valid_match: assert property (@(posedge clk) disable iff (!reset)
    rd_valid == (count != {CW{1'b0}}));
  a_empty_zero: assert property (@(posedge clk) disable iff (!reset)
    !rd_valid |-> (rd_data == 7'd0));

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed bench for alu_result_fifo against a queue-based reference model.

module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    alu_in;
  logic          rd_en;
  logic          clr_ovf;
  logic [6:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic [7:0]    op_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [6:0] mq[$];
  logic       m_prev_done;
  logic       m_ovf;
  int         m_ops;

  alu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_in   (alu_in),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] exp_vec();
    logic [6:0] head;
    head = (mq.size() != 0) ? mq[0] : 7'd0;
    return {mq.size() != 0, head, CW'(mq.size()), mq.size() == DEPTH, m_ovf, 8'(m_ops % 256)};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {rd_valid, rd_data, count, full, overflow, op_count};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_prev_done = 1'b0;
    m_ovf       = 1'b0;
    m_ops       = 0;
  endtask

  task automatic model_step(input logic [7:0] a, input logic r, input logic c);
    bit push, pop, drop;
    push = a[4] && !m_prev_done;
    m_prev_done = a[4];
    pop  = r && (mq.size() > 0);
    drop = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      m_ops++;
      if (mq.size() < DEPTH) mq.push_back({a[7:5], a[3:0]});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic [7:0] a, input logic r, input logic c);
    alu_in  = a;
    rd_en   = r;
    clr_ovf = c;
    @(posedge clk);
    model_step(a, r, c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; alu_in = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; alu_in = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
    #2;
    n_cmp++;
    if (obs_vec() !== 21'd0) begin
      n_err++; $display("FAIL reset_init: got %h want 0", obs_vec());
    end
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      cycle(8'h10 | 8'(i), 1'b0, 1'b0);
      cycle(8'h00, 1'b0, 1'b0);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec() || count !== 3'd3) begin
      n_err++; $display("FAIL reset_prefill: got %h want %h", obs_vec(), exp_vec());
    end
    #2 reset = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (obs_vec() !== 21'd0) begin
      n_err++; $display("FAIL reset_async: got %h want 0", obs_vec());
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_capture();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(8'h13, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL single_hold: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (rd_data !== 7'h03 || count !== 3'd1 || op_count !== 8'd1) begin
      n_err++; $display("FAIL single_entry: got data %h cnt %0d ops %0d want 03 1 1", rd_data, count, op_count);
    end
    cycle(8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 7'h00) begin
      n_err++; $display("FAIL single_pop: got valid %b data %h want 0 00", rd_valid, rd_data);
    end
  endtask

  task automatic test_order_flags();
    logic [7:0] seq [7];
    logic [6:0] want [3];
    seq = '{8'hB3, 8'h00, 8'h40, 8'h50, 8'h00, 8'h1F, 8'h00};
    want = '{7'h53, 7'h20, 7'h0F};
    do_reset();
    foreach (seq[i]) cycle(seq[i], 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd3 || op_count !== 8'd3) begin
      n_err++; $display("FAIL order_fill: got cnt %0d ops %0d want 3 3", count, op_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_data !== want[i] || obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL order_pop%0d: got %h want %h", i, rd_data, want[i]);
      end
      cycle(8'h00, 1'b1, 1'b0);
    end
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL order_empty: got valid %b want 0", rd_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(8'h10 | 8'(i), 1'b0, 1'b0);
      cycle(8'h00, 1'b0, 1'b0);
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1 || op_count !== 8'd5) begin
      n_err++; $display("FAIL ovf_state: got full %b cnt %0d ovf %b ops %0d want 1 4 1 5", full, count, overflow, op_count);
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (rd_data !== 7'(i) || obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ovf_pop: got %h want %h", rd_data, 7'(i));
      end
      cycle(8'h00, 1'b1, 1'b0);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    cycle(8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cycle(8'h10 | 8'(i), 1'b0, 1'b0);
      cycle(8'h00, 1'b0, 1'b0);
    end
    cycle(8'h15, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
      n_err++; $display("FAIL full_simul: got cnt %0d ovf %b full %b want 4 0 1", count, overflow, full);
    end
    for (int i = 2; i <= 5; i++) begin
      n_cmp++;
      if (rd_data !== 7'(i) || obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL full_simul_pop: got %h want %h", rd_data, 7'(i));
      end
      cycle(8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap_empty();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(8'h10 | 8'(i), 1'b0, 1'b0);
      n_cmp++;
      if (rd_data !== 7'(i) || count !== 3'd1) begin
        n_err++; $display("FAIL wrap_push%0d: got %h cnt %0d want %h 1", i, rd_data, count, 7'(i));
      end
      cycle(8'h00, 1'b1, 1'b0);
    end
    cycle(8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL empty_pop: got cnt %0d valid %b ovf %b want 0 0 0", count, rd_valid, overflow);
    end
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      cycle(8'h10 | 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      cycle(8'h00, 1'b1, 1'b0);
      if (i == 255) begin
        n_cmp++;
        if (op_count !== 8'd255) begin
          n_err++; $display("FAIL opcount_255: got %0d want 255", op_count);
        end
      end
    end
    n_cmp++;
    if (op_count !== 8'd0 || obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL opcount_wrap: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      a = 8'($urandom);
      cycle(a, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_order_flags();
    test_overflow();
    test_full_push_pop();
    test_wrap_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
